mem_dispatch_queue: RTL and testbench
=====================================

MEM_DISPATCH_QUEUE -- requirements
Module: mem_dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter AL_W, default 6, active_list_id width.
REQ-003 SHALL have parameter HIST, default 2, number of recently dispatched stores tracked for bypass.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous pipeline flush; discards queued entries.
REQ-007 dc_miss  in  1  d_cache miss stall from hazard logic; blocks dispatch.
REQ-008 in_valid  in  1  new memory op offered.
REQ-009 in_ready  out  1  queue can accept; equals not-full.
REQ-010 in_mem_action  in  1  READ=0, WRITE=1.
REQ-011 in_addr  in  32  byte address.
REQ-012 in_data  in  32  store data (don't-care for READ).
REQ-013 in_al_id  in  AL_W  active list id of op.
REQ-014 out_valid  out  1  head op dispatched this cycle toward the e2m register.
REQ-015 out_mem_action, out_addr, out_data  out  1/32/32  head entry fields.
REQ-016 out_nop  out  1  high when no op is dispatched (inverse of out_valid).
REQ-017 out_dispatch_index  out  log2(DEPTH)  slot index of head entry.
REQ-018 out_al_id  out  AL_W  head active list id.
REQ-019 out_bypass_possible  out  1  head READ matches a tracked recent store word address.
REQ-020 out_bypass_index  out  log2(HIST)  history slot of youngest matching store (0 = youngest).
REQ-021 count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-022 SHALL be a circular in-order FIFO with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH.
REQ-023 Enqueue SHALL occur when in_valid && in_ready && !flush; entry written at tail, tail+1.
REQ-024 in_ready SHALL be (count != DEPTH); a full queue SHALL NOT accept even if dequeuing same cycle.
REQ-025 out_valid SHALL be (count != 0) && !dc_miss, combinational from head; zero-latency head presentation.
REQ-026 Dequeue SHALL occur on posedge when out_valid is high; head+1.
REQ-027 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-028 When count==0, out_valid=0, out_nop=1, out_bypass_possible=0; other out fields don't-care.
REQ-029 While dc_miss=1, head, count and history SHALL hold; enqueue SHALL still proceed if not full.
REQ-030 Store history SHALL be a HIST-deep shift register of {valid, addr[31:2]}; a dispatched WRITE shifts in at slot 0.
REQ-031 out_bypass_possible SHALL be 1 iff head is READ, out_valid=1, and some valid history slot has addr[31:2]==head addr[31:2]; lowest matching slot index drives out_bypass_index.
REQ-032 A dispatched READ, or an idle cycle, SHALL NOT alter history contents.
REQ-033 flush SHALL clear head, tail, count and all entry valids at posedge, taking priority over enqueue and dequeue in that cycle; history SHALL be retained (dispatched stores are committed).
REQ-034 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-035 On rst_n=0, asynchronously: head=tail=0, count=0, history valids=0; hence out_valid=0, out_nop=1, in_ready=1, out_bypass_possible=0.
REQ-036 Reset asserted mid-operation SHALL discard all entries and history immediately, independent of clk.

Verification
REQ-037 Fill: 8 enqueues, no dispatch (dc_miss=1) -> count=8, in_ready=0; 9th in_valid ignored; deassert dc_miss -> 8 ops dispatched in order, out_dispatch_index 0..7.
REQ-038 Wrap: enqueue 6, dispatch 6, enqueue 4 -> out_dispatch_index 6,7,0,1; count returns to 0, out_nop=1.
REQ-039 Bypass: dispatch WRITE 0x1004, then READ 0x1006 -> out_bypass_possible=1, out_bypass_index=0; READ 0x1008 -> 0.
REQ-040 Bypass depth: WRITE 0x200, WRITE 0x300, READ 0x200 -> bypass_possible=1, index=1; third WRITE 0x400 then READ 0x200 -> 0.
REQ-041 Flush with enqueue: count=3, flush=1 and in_valid=1 same cycle -> count=0, in_ready=1, history unchanged.
REQ-042 Async reset mid-burst: count=5, drop rst_n between edges -> out_valid=0 and count=0 before next posedge.

Source files
------------

// File: rtl/mem_dispatch_queue_if.sv
// Enqueue and dispatch bus of the memory dispatch queue, plus flush/stall controls.
interface mem_dispatch_queue_if #(
    parameter int DEPTH = 8,
    parameter int AL_W  = 6,
    parameter int HIST  = 2
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI_W  = (HIST > 1) ? $clog2(HIST) : 1;

    logic              flush;
    logic              dc_miss;
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_action;
    logic [31:0]       in_addr;
    logic [31:0]       in_data;
    logic [AL_W-1:0]   in_al_id;
    logic              out_valid;
    logic              out_mem_action;
    logic [31:0]       out_addr;
    logic [31:0]       out_data;
    logic              out_nop;
    logic [IDX_W-1:0]  out_dispatch_index;
    logic [AL_W-1:0]   out_al_id;
    logic              out_bypass_possible;
    logic [HI_W-1:0]   out_bypass_index;
    logic [IDX_W:0]    count;

    modport master (
        output flush, dc_miss, in_valid, in_mem_action, in_addr, in_data, in_al_id,
        input  in_ready, out_valid, out_mem_action, out_addr, out_data, out_nop,
               out_dispatch_index, out_al_id, out_bypass_possible, out_bypass_index, count
    );

    modport slave (
        input  flush, dc_miss, in_valid, in_mem_action, in_addr, in_data, in_al_id,
        output in_ready, out_valid, out_mem_action, out_addr, out_data, out_nop,
               out_dispatch_index, out_al_id, out_bypass_possible, out_bypass_index, count
    );
endinterface

// File: rtl/mem_dispatch_queue.sv
// In-order memory op FIFO with zero-latency head dispatch and a short history
// of dispatched store word addresses used to flag store-to-load bypass.
module mem_dispatch_queue #(
    parameter int DEPTH = 8,
    parameter int AL_W  = 6,
    parameter int HIST  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_dispatch_queue_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI_W  = (HIST > 1) ? $clog2(HIST) : 1;
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    typedef struct packed {
        logic            mem_action;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [AL_W-1:0] al_id;
    } entry_t;

    entry_t                 slots [DEPTH];
    entry_t                 head_e;
    logic [IDX_W-1:0]       head, tail;
    logic [IDX_W:0]         count_q;
    logic [HIST-1:0]        hist_v;
    logic [HIST-1:0][29:0]  hist_a;
    logic                   full, empty, enq, deq;
    logic                   hit;
    logic [HI_W-1:0]        hit_idx;

    assign head_e = slots[head];
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    // A full queue refuses even when the head leaves this cycle.
    assign enq    = bus.in_valid && !full && !bus.flush;
    assign deq    = !empty && !bus.dc_miss;

    assign bus.in_ready           = !full;
    assign bus.out_valid          = deq;
    assign bus.out_nop            = !deq;
    assign bus.out_mem_action     = head_e.mem_action;
    assign bus.out_addr           = head_e.addr;
    assign bus.out_data           = head_e.data;
    assign bus.out_al_id          = head_e.al_id;
    assign bus.out_dispatch_index = head;
    assign bus.count              = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            hist_v  <= '0;
            hist_a  <= '0;
        end else if (bus.flush) begin
            // Stores already dispatched are committed, so history survives a flush.
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (deq && head_e.mem_action) begin
                for (int i = HIST-1; i > 0; i--) begin
                    hist_v[i] <= hist_v[i-1];
                    hist_a[i] <= hist_a[i-1];
                end
                hist_v[0] <= 1'b1;
                hist_a[0] <= head_e.addr[31:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            slots[tail] <= '{bus.in_mem_action, bus.in_addr, bus.in_data, bus.in_al_id};
    end

    // Scan oldest to youngest so the youngest matching store wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = HIST-1; i >= 0; i--) begin
            if (hist_v[i] && hist_a[i] == head_e.addr[31:2]) begin
                hit     = 1'b1;
                hit_idx = HI_W'(i);
            end
        end
    end

    assign bus.out_bypass_possible = hit && deq && !head_e.mem_action;
    assign bus.out_bypass_index    = hit_idx;
endmodule

// File: tb/tb_mem_dispatch_queue.sv
// Directed and random stimulus for mem_dispatch_queue against a queue-based model.
module tb_mem_dispatch_queue;
    localparam int DEPTH = 8;
    localparam int AL_W  = 6;
    localparam int HIST  = 2;

    logic clk, rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        bit            act;
        bit [31:0]     addr;
        bit [31:0]     data;
        bit [AL_W-1:0] id;
        int            slot;
    } ment_t;

    ment_t     q[$];
    bit [29:0] hist[$];
    int        mtail = 0;

    mem_dispatch_queue_if #(.DEPTH(DEPTH), .AL_W(AL_W), .HIST(HIST)) bus ();

    mem_dispatch_queue #(.DEPTH(DEPTH), .AL_W(AL_W), .HIST(HIST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] raddr();
        return 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
    endfunction

    // Called at a negedge: drive, check combinational outputs, clock, update model.
    task automatic step(input bit v, input bit act, input bit [31:0] a, input bit [31:0] d,
                        input bit fl, input bit dm);
        bit            exp_valid, exp_byp, en;
        int            exp_bi;
        ment_t         e;
        bit [AL_W-1:0] id;
        id                = AL_W'($urandom);
        bus.in_valid      = v;
        bus.in_mem_action = act;
        bus.in_addr       = a;
        bus.in_data       = d;
        bus.in_al_id      = id;
        bus.flush         = fl;
        bus.dc_miss       = dm;
        #1;
        exp_valid = (q.size() != 0) && !dm;
        chk("in_ready", bus.in_ready, q.size() != DEPTH);
        chk("count", bus.count, q.size());
        chk("out_valid", bus.out_valid, exp_valid);
        chk("out_nop", bus.out_nop, !exp_valid);
        if (exp_valid) begin
            e = q[0];
            chk("out_mem_action", bus.out_mem_action, e.act);
            chk("out_addr", bus.out_addr, e.addr);
            chk("out_data", bus.out_data, e.data);
            chk("out_al_id", bus.out_al_id, e.id);
            chk("out_dispatch_index", bus.out_dispatch_index, e.slot);
            exp_byp = 1'b0;
            exp_bi  = 0;
            if (!e.act) begin
                for (int i = 0; i < hist.size(); i++) begin
                    if (hist[i] == e.addr[31:2]) begin
                        exp_byp = 1'b1;
                        exp_bi  = i;
                        break;
                    end
                end
            end
            chk("out_bypass_possible", bus.out_bypass_possible, exp_byp);
            if (exp_byp) chk("out_bypass_index", bus.out_bypass_index, exp_bi);
        end else begin
            chk("out_bypass_possible_idle", bus.out_bypass_possible, 1'b0);
        end
        en = v && (q.size() != DEPTH);
        @(posedge clk);
        if (fl) begin
            q.delete();
            mtail = 0;
        end else begin
            if (exp_valid) begin
                e = q.pop_front();
                if (e.act) begin
                    hist.push_front(e.addr[31:2]);
                    if (hist.size() > HIST) void'(hist.pop_back());
                end
            end
            if (en) begin
                q.push_back('{act, a, d, id, mtail});
                mtail = (mtail + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_mem_action = 0; bus.in_addr = 0; bus.in_data = 0;
        bus.in_al_id = 0; bus.flush = 0; bus.dc_miss = 0;
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_nop", bus.out_nop, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_count", bus.count, 0);
        chk("rst_bypass", bus.out_bypass_possible, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill while stalled, one extra offer while full, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            step(1, $urandom_range(0, 1) == 1, 32'h8000_0000 + 32'(i * 16), $urandom, 0, 1);
        step(1, 1, 32'h8000_1000, 32'hdead_beef, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Pointer wrap: slots 6,7,0,1 for the second batch.
        for (int i = 0; i < 6; i++) step(1, 0, 32'h9000_0000 + 32'(i * 4), $urandom, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 32'h9100_0000 + 32'(i * 4), $urandom, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);

        // Bypass on same word, none on the next word.
        step(1, 1, 32'h1004, 32'h11, 0, 0);
        step(1, 0, 32'h1006, 0, 0, 0);
        step(1, 0, 32'h1008, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // History depth: older store at index 1, evicted after a third store.
        step(1, 1, 32'h200, 32'h22, 0, 0);
        step(1, 1, 32'h300, 32'h33, 0, 0);
        step(1, 0, 32'h200, 0, 0, 0);
        step(1, 1, 32'h400, 32'h44, 0, 0);
        step(1, 0, 32'h200, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Flush beats a same-cycle enqueue; history still flags 0x300 at index 1.
        for (int i = 0; i < 3; i++) step(1, 0, 32'h500 + 32'(i * 4), 0, 0, 1);
        step(1, 0, 32'h600, 0, 1, 1);
        step(1, 0, 32'h300, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic on a small address pool.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, raddr(), $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);

        // Async reset between edges mid-burst.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h700, 32'h77, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 32'ha00 + 32'(i * 4), 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 1'b0);
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_in_ready", bus.in_ready, 1'b1);
        chk("async_rst_out_nop", bus.out_nop, 1'b1);
        q.delete();
        hist.delete();
        mtail = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 32'h700, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
